// File: rtl/reg_hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_hazard_scoreboard_pkg
//  Description : Shared defaults and update-mode encoding for the decode-stage
//                register hazard scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_hazard_scoreboard_pkg;

    // Defaults shared with the decode and forwarding units.
    localparam int c_reg_w_def = 3;
    localparam int c_depth_def = 3;

    typedef enum logic [1:0] {
        UPD_SHIFT = 2'd0,
        UPD_HOLD  = 2'd1,
        UPD_FLUSH = 2'd2
    } upd_mode_e;

endpackage
`default_nettype wire

// File: rtl/reg_id_eq.sv
`default_nettype none
// ============================================================================
//  Module      : reg_id_eq
//  Description : W-bit register-ID equality comparator (per-bit XNOR, AND-reduced).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_id_eq #(
    parameter int W = 3
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_eq
);

    logic [W-1:0] w_bit_eq;

    assign w_bit_eq = ~(i_a ^ i_b);
    assign o_eq     = &w_bit_eq;

endmodule
`default_nettype wire

// File: rtl/reg_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_hazard_scoreboard
//  Description : Tracks in-flight destination IDs and flags RAW hazards at decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_hazard_scoreboard
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int REG_W     = c_reg_w_def,
    parameter int DEPTH     = c_depth_def,
    parameter int BYPASS_WB = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_dst,
    input  logic [REG_W-1:0] id_src_a,
    input  logic             id_src_a_vld,
    input  logic [REG_W-1:0] id_src_b,
    input  logic             id_src_b_vld,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic [DEPTH-1:0] hazard_vec,
    output logic [CNT_W-1:0] stall_cnt
);

    // The WB slot writes the register file before decode reads it, so it can be masked.
    localparam logic [DEPTH-1:0] c_cmp_mask = (BYPASS_WB != 0) ? ({DEPTH{1'b1}} >> 1)
                                                               : {DEPTH{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    logic [DEPTH-1:0]       r_vld;
    logic [DEPTH*REG_W-1:0] r_dst;
    logic [CNT_W-1:0]       r_cnt;
    logic [DEPTH-1:0]       w_eq_a;
    logic [DEPTH-1:0]       w_eq_b;
    logic [DEPTH-1:0]       w_hit;
    logic                   w_issue;
    upd_mode_e              w_mode;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            reg_id_eq #(.W(REG_W)) u_eq_a (
                .i_a  (id_src_a),
                .i_b  (r_dst[i*REG_W +: REG_W]),
                .o_eq (w_eq_a[i])
            );
            reg_id_eq #(.W(REG_W)) u_eq_b (
                .i_a  (id_src_b),
                .i_b  (r_dst[i*REG_W +: REG_W]),
                .o_eq (w_eq_b[i])
            );
        end
    endgenerate

    assign w_hit      = ({DEPTH{id_src_a_vld}} & w_eq_a) | ({DEPTH{id_src_b_vld}} & w_eq_b);
    assign hazard_vec = r_vld & w_hit & c_cmp_mask;
    assign stall      = id_valid & (|hazard_vec);
    assign w_issue    = id_valid & id_wr_en & ~stall;
    assign stall_cnt  = r_cnt;

    always_comb begin
        w_mode = UPD_SHIFT;
        if (flush) begin
            w_mode = UPD_FLUSH;
        end else if (hold) begin
            w_mode = UPD_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_dst <= '0;
        end else begin
            case (w_mode)
                UPD_FLUSH: r_vld <= '0;
                UPD_HOLD: ;
                default: begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        r_vld[i]                 <= r_vld[i-1];
                        r_dst[i*REG_W +: REG_W]  <= r_dst[(i-1)*REG_W +: REG_W];
                    end
                    // A bubble leaves slot 0's ID untouched; only vld marks it empty.
                    r_vld[0] <= w_issue;
                    if (w_issue) begin
                        r_dst[REG_W-1:0] <= id_dst;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (stall && !flush && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
